// File: rtl/ddr_word_rx.sv
// Dual-edge byte receiver: pairs rise/fall bytes, hunts for a sync word, then queues aligned words.
// Optional DDR_RX_STATS_EN adds pushed-word and dropped-word counters.
module ddr_word_rx #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        resync,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        locked,
    output logic        overflow,
    output logic        dbg_state
`ifdef DDR_RX_STATS_EN
    ,
    output logic [15:0] word_cnt,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    rise_q;
    logic [7:0]    fall_q;
    logic          pend_q;
    logic [15:0]   pair;
    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          push_req;
    logic          resync_drop;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_drop;

    // Fall byte is taken half a cycle after the rise byte; no qualifier at this edge.
    always_ff @(negedge clk) begin
        if (rst) fall_q <= '0;
        else     fall_q <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= din_vld;
            if (din_vld) rise_q <= din;
        end
    end

    assign pair = {fall_q, rise_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (!resync && pend_q && pair == SYNC_WORD) state_d = LOCKED;
            LOCKED:  if (resync) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Resync outranks a push completing in the same cycle.
    always_comb begin
        locked      = (state_q == LOCKED);
        dbg_state   = state_q;
        push_req    = (state_q == LOCKED) && pend_q && !resync;
        resync_drop = (state_q == LOCKED) && pend_q && resync;
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = !empty && dout_ready;
    assign push_ok  = push_req && (!full || pop);
    assign ovf_drop = push_req && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q | ovf_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= pair;
    end

    assign dout       = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
    assign dout_valid = !empty;
    assign overflow   = overflow_q;

`ifdef DDR_RX_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q + {15'd0, push_ok};
        drop_cnt_d = drop_cnt_q;
        if ((ovf_drop || resync_drop) && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_word_rx.sv
// Directed bench for ddr_word_rx: lock, hunt discard, backpressure, full push+pop, resync, reset.
// Stats checks are included when DDR_RX_STATS_EN is defined.
module tb_ddr_word_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic        resync = 1'b0;
    logic        dout_ready = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        locked;
    logic        overflow;
    logic        dbg_state;
`ifdef DDR_RX_STATS_EN
    logic [15:0] word_cnt;
    logic [7:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ddr_word_rx #(.DEPTH(4), .SYNC_WORD(16'hA55A)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_vld    (din_vld),
        .resync     (resync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .locked     (locked),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
`ifdef DDR_RX_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: rise byte for the posedge, fall byte for the following negedge.
    // Returns just after the negedge so outputs are sampled mid-cycle.
    task automatic step(input logic [7:0] rise, input logic vld, input logic [7:0] fall);
        din     = rise;
        din_vld = vld;
        @(posedge clk);
        #1;
        din     = fall;
        din_vld = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, {15'd0, dout_valid}, 16'd1);
        check({tag, "_dout"}, dout, exp);
        dout_ready = 1'b1;
        idle();
        dout_ready = 1'b0;
    endtask

    initial begin
        // T1: lock on A55A, then two data words; sync itself never appears.
        do_reset();
        check("rst_dout", dout, 16'h0000);
        check("rst_valid", {15'd0, dout_valid}, 16'd0);
        check("rst_locked", {15'd0, locked}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
`ifdef DDR_RX_STATS_EN
        check("rst_wcnt", word_cnt, 16'd0);
        check("rst_dcnt", {8'd0, drop_cnt}, 16'd0);
`endif
        step(8'h5A, 1'b1, 8'hA5);
        check("t1_pre_lock", {15'd0, locked}, 16'd0);
        step(8'h14, 1'b1, 8'h1E);
        check("t1_locked", {15'd0, locked}, 16'd1);
        check("t1_no_sync", {15'd0, dout_valid}, 16'd0);
        step(8'h28, 1'b1, 8'h32);
        check("t1_lat_valid", {15'd0, dout_valid}, 16'd1);
        check("t1_lat_dout", dout, 16'h1E14);
        idle();
        pop_expect("t1_w0", 16'h1E14);
        pop_expect("t1_w1", 16'h3228);
        check("t1_empty", {15'd0, dout_valid}, 16'd0);

        // T2: 1234 discarded in HUNT, lock on A55A, later A55A is ordinary data.
        do_reset();
        step(8'h34, 1'b1, 8'h12);
        step(8'h5A, 1'b1, 8'hA5);
        check("t2_hunt_locked", {15'd0, locked}, 16'd0);
        check("t2_hunt_valid", {15'd0, dout_valid}, 16'd0);
        step(8'h01, 1'b1, 8'h00);
        check("t2_locked", {15'd0, locked}, 16'd1);
        check("t2_no_sync", {15'd0, dout_valid}, 16'd0);
        step(8'h5A, 1'b1, 8'hA5);
        idle();
        pop_expect("t2_w0", 16'h0001);
        pop_expect("t2_sync_data", 16'hA55A);
        check("t2_empty", {15'd0, dout_valid}, 16'd0);

        // T3: no consumer, five words into a four-deep FIFO.
        do_reset();
        step(8'h5A, 1'b1, 8'hA5);
        step(8'h11, 1'b1, 8'h11);
        step(8'h22, 1'b1, 8'h22);
        check("t3_head0", dout, 16'h1111);
        step(8'h33, 1'b1, 8'h33);
        step(8'h44, 1'b1, 8'h44);
        check("t3_head1", dout, 16'h1111);
        step(8'h55, 1'b1, 8'h55);
        check("t3_full_ovf", {15'd0, overflow}, 16'd0);
        idle();
        check("t3_ovf", {15'd0, overflow}, 16'd1);
        check("t3_head2", dout, 16'h1111);
`ifdef DDR_RX_STATS_EN
        check("t3_wcnt", word_cnt, 16'd4);
        check("t3_dcnt", {8'd0, drop_cnt}, 16'd1);
`endif
        pop_expect("t3_w0", 16'h1111);
        pop_expect("t3_w1", 16'h2222);
        pop_expect("t3_w2", 16'h3333);
        pop_expect("t3_w3", 16'h4444);
        check("t3_empty", {15'd0, dout_valid}, 16'd0);
        check("t3_ovf_sticky", {15'd0, overflow}, 16'd1);

        // T4: full FIFO, pop and push in the same cycle.
        do_reset();
        step(8'h5A, 1'b1, 8'hA5);
        step(8'h02, 1'b1, 8'h01);
        step(8'h04, 1'b1, 8'h03);
        step(8'h06, 1'b1, 8'h05);
        step(8'h08, 1'b1, 8'h07);
        step(8'h0A, 1'b1, 8'h09);
        check("t4_full_head", dout, 16'h0102);
        dout_ready = 1'b1;
        idle();
        dout_ready = 1'b0;
        check("t4_ovf", {15'd0, overflow}, 16'd0);
        pop_expect("t4_w1", 16'h0304);
        pop_expect("t4_w2", 16'h0506);
        pop_expect("t4_w3", 16'h0708);
        pop_expect("t4_w4", 16'h090A);
        check("t4_empty", {15'd0, dout_valid}, 16'd0);

        // T5: din_vld gap keeps lock; resync drops the coinciding pair and re-hunts.
        do_reset();
        step(8'h5A, 1'b1, 8'hA5);
        step(8'h22, 1'b1, 8'h11);
        idle();
        pop_expect("t5_w0", 16'h1122);
        idle();
        idle();
        check("t5_gap_locked", {15'd0, locked}, 16'd1);
        check("t5_gap_valid", {15'd0, dout_valid}, 16'd0);
        step(8'h44, 1'b1, 8'h33);
        resync = 1'b1;
        step(8'h78, 1'b1, 8'h56);
        resync = 1'b0;
        check("t5_resync_locked", {15'd0, locked}, 16'd0);
        check("t5_resync_drop", {15'd0, dout_valid}, 16'd0);
`ifdef DDR_RX_STATS_EN
        check("t5_dcnt", {8'd0, drop_cnt}, 16'd1);
`endif
        step(8'h5A, 1'b1, 8'hA5);
        check("t5_hunt_locked", {15'd0, locked}, 16'd0);
        check("t5_hunt_valid", {15'd0, dout_valid}, 16'd0);
        step(8'hBC, 1'b1, 8'h9A);
        check("t5_relock", {15'd0, locked}, 16'd1);
        idle();
        pop_expect("t5_w1", 16'h9ABC);

        // T6: reset with three words queued.
        do_reset();
        step(8'h5A, 1'b1, 8'hA5);
        step(8'h01, 1'b1, 8'h01);
        step(8'h02, 1'b1, 8'h02);
        step(8'h03, 1'b1, 8'h03);
        idle();
        check("t6_pre_valid", {15'd0, dout_valid}, 16'd1);
`ifdef DDR_RX_STATS_EN
        check("t6_pre_wcnt", word_cnt, 16'd3);
`endif
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("t6_valid", {15'd0, dout_valid}, 16'd0);
        check("t6_locked", {15'd0, locked}, 16'd0);
        check("t6_ovf", {15'd0, overflow}, 16'd0);
        check("t6_dout", dout, 16'h0000);
`ifdef DDR_RX_STATS_EN
        check("t6_wcnt", word_cnt, 16'd0);
        check("t6_dcnt", {8'd0, drop_cnt}, 16'd0);
`endif
        step(8'h22, 1'b1, 8'h11);
        idle();
        check("t6_relock_needed", {15'd0, dout_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
